// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ADD/SUB/AND/ORR/MUL,
// iterative restoring divider (quotient + remainder) and iterative power unit.
module alu_seq #(
    parameter int WIDTH    = 32,
    parameter int EXP_BITS = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic [3:0]       ALUFlags,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC_DIV, EXEC_POW, DONE} state_t;

    localparam int CLOG_W = $clog2(WIDTH + 1);
    localparam int CNT_W  = (CLOG_W > EXP_BITS) ? CLOG_W : EXP_BITS;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH:0]     add_sum, sub_diff, div_trial, div_diff;
    logic [2*WIDTH-1:0] mul_prod, pow_prod;
    logic [EXP_BITS-1:0] exp_e;
    logic               div_bit;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == EXEC_DIV) || (state_q == EXEC_POW);
    assign Result    = result_q;
    assign Remainder = rem_q;
    assign ALUFlags  = flags_q;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    always_comb begin
        add_sum  = {1'b0, A} + {1'b0, B};
        sub_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        mul_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        pow_prod = {{WIDTH{1'b0}}, result_q} * {{WIDTH{1'b0}}, opb_q};
        exp_e    = B[EXP_BITS-1:0];

        // Restoring step: result_q shifts the dividend out MSB-first and the quotient in.
        div_trial = {rem_q, result_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb_q};
        div_bit   = (div_trial >= {1'b0, opb_q});
        div_quo   = {result_q[WIDTH-2:0], div_bit};
        div_rem   = div_bit ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;

        case (state_q)
            EXEC_DIV: begin
                result_d = div_quo;
                rem_d    = div_rem;
                flags_d  = mk_flags(div_quo, 1'b0, 1'b0);
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            EXEC_POW: begin
                result_d = pow_prod[WIDTH-1:0];
                flags_d  = mk_flags(pow_prod[WIDTH-1:0], 1'b0,
                                    flags_q[0] | (|pow_prod[2*WIDTH-1:WIDTH]));
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            default: begin
                if ((state_q == DONE) && out_ready) state_d = IDLE;
                if (accept) begin
                    state_d = DONE;
                    rem_d   = '0;
                    cnt_d   = '0;
                    case (ALUControl)
                        3'b000: begin
                            result_d = add_sum[WIDTH-1:0];
                            flags_d  = mk_flags(result_d, add_sum[WIDTH],
                                                (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]));
                        end
                        3'b001: begin
                            result_d = sub_diff[WIDTH-1:0];
                            flags_d  = mk_flags(result_d, sub_diff[WIDTH],
                                                (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]));
                        end
                        3'b010: begin
                            result_d = A & B;
                            flags_d  = mk_flags(result_d, 1'b0, 1'b0);
                        end
                        3'b011: begin
                            result_d = A | B;
                            flags_d  = mk_flags(result_d, 1'b0, 1'b0);
                        end
                        3'b100: begin
                            result_d = mul_prod[WIDTH-1:0];
                            flags_d  = mk_flags(result_d, 1'b0, |mul_prod[2*WIDTH-1:WIDTH]);
                        end
                        3'b101: begin
                            if (B == '0) begin
                                result_d = '0;
                                rem_d    = A;
                                flags_d  = mk_flags('0, 1'b0, 1'b1);
                            end else begin
                                state_d  = EXEC_DIV;
                                result_d = A;
                                opb_d    = B;
                                flags_d  = '0;
                                cnt_d    = CNT_W'(WIDTH);
                            end
                        end
                        3'b110: begin
                            if (exp_e == '0) begin
                                result_d = WIDTH'(1);
                                flags_d  = mk_flags(result_d, 1'b0, 1'b0);
                            end else if (exp_e == EXP_BITS'(1)) begin
                                result_d = A;
                                flags_d  = mk_flags(result_d, 1'b0, 1'b0);
                            end else begin
                                state_d  = EXEC_POW;
                                result_d = A;
                                opb_d    = A;
                                flags_d  = '0;
                                cnt_d    = CNT_W'(exp_e) - CNT_W'(1);
                            end
                        end
                        default: begin
                            result_d = '0;
                            flags_d  = mk_flags('0, 1'b0, 1'b0);
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq, checked every cycle against a
// transaction-level arithmetic model (64-bit arithmetic, division operator, loops).
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] A = '0, B = '0, Result, Remainder;
    logic [2:0]   ALUControl = '0;
    logic [3:0]   ALUFlags;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W), .EXP_BITS(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Remainder(Remainder),
        .ALUFlags(ALUFlags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, res, rem;
        logic [3:0]   fl;
        int           lat;
        int           t;
    } txn_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Expected outcome of one operation straight from the arithmetic definitions.
    function automatic txn_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        txn_t x;
        logic [63:0] p;
        logic [W-1:0] r;
        logic c, v;
        int e;
        r = '0; c = 1'b0; v = 1'b0;
        x.op = op; x.a = a; x.b = b; x.rem = '0; x.lat = 1; x.t = 0;
        case (op)
            3'd0: begin
                p = 64'(a) + 64'(b);
                r = p[31:0]; c = p[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin
                p = 64'(a) * 64'(b);
                r = p[31:0]; v = (p[63:32] != 0);
            end
            3'd5: begin
                if (b == 0) begin r = '0; x.rem = a; v = 1'b1; end
                else begin r = a / b; x.rem = a % b; x.lat = W + 1; end
            end
            3'd6: begin
                e = int'(b[4:0]);
                if (e == 0) r = 1;
                else begin
                    r = a;
                    for (int i = 1; i < e; i++) begin
                        p = 64'(r) * 64'(a);
                        if (p[63:32] != 0) v = 1'b1;
                        r = p[31:0];
                    end
                    if (e >= 2) x.lat = e;
                end
            end
            default: r = '0;
        endcase
        x.res = r;
        x.fl  = {r[31], (r == 0), c, v};
        return x;
    endfunction

    txn_t q[$];
    int n_done = 0, busy_cnt = 0, first_cyc = 0, last_lat = 0;
    bit seen = 1'b0;
    logic [W-1:0] last_res = '0, last_rem = '0;
    logic [3:0] last_fl = '0;

    initial begin : monitor
        txn_t x;
        bit exp_ov, exp_ir;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_result", Result, 0);
                chk("rst_remainder", Remainder, 0);
                chk("rst_flags", ALUFlags, 0);
                q.delete();
                seen = 1'b0;
            end else begin
                exp_ov = (q.size() > 0) && (cyc >= q[0].t + q[0].lat);
                exp_ir = (q.size() == 0) || (exp_ov && out_ready);
                chk("out_valid", out_valid, exp_ov);
                chk("busy", busy, (q.size() > 0) && !exp_ov);
                chk("in_ready", in_ready, exp_ir);
                if (busy) busy_cnt++;
                if (q.size() > 0 && out_valid && !seen) begin
                    seen = 1'b1;
                    first_cyc = cyc;
                end
                if (exp_ov) begin
                    chk("result", Result, q[0].res);
                    chk("remainder", Remainder, q[0].rem);
                    chk("flags", ALUFlags, q[0].fl);
                    if (out_ready) begin
                        last_res = Result; last_rem = Remainder; last_fl = ALUFlags;
                        last_lat = first_cyc - q[0].t;
                        $display("txn %0d op=%0d A=%h B=%h -> R=%h rem=%h flags=%b lat=%0d",
                                 n_done, q[0].op, q[0].a, q[0].b, Result, Remainder, ALUFlags, last_lat);
                        n_done++;
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
                if (in_valid && exp_ir) begin
                    x = model(ALUControl, A, B);
                    x.t = cyc;
                    q.push_back(x);
                end
            end
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bit ok;
        ALUControl = op; A = a; B = b; in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (ok) break;
            if (waited > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALUControl = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_done < target) chk("done_timeout", n_done, target);
    endtask

    task automatic run1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int w, tgt;
        tgt = n_done + 1;
        send(op, a, b, w);
        idle();
        wait_done(tgt);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 15));
            1:       return 32'h7FFF_FFFF + W'($urandom_range(0, 3));
            2:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin : driver
        int w0, w1, w2, tgt, k, done0;
        logic [2:0] op;
        logic [W-1:0] a, b;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        run1(3'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add_res", last_res, 32'h8000_0000);
        chk("add_flags", last_fl, 4'b1001);
        chk("add_lat", last_lat, 1);
        run1(3'd1, 32'd5, 32'd5);
        chk("sub_res", last_res, 0);
        chk("sub_flags", last_fl, 4'b0110);

        busy_cnt = 0;
        run1(3'd5, 32'd100, 32'd7);
        chk("div_res", last_res, 14);
        chk("div_rem", last_rem, 2);
        chk("div_flags", last_fl, 4'b0000);
        chk("div_lat", last_lat, 33);
        chk("div_busy_cycles", busy_cnt, 32);
        run1(3'd5, 32'd9, 32'd0);
        chk("div0_res", last_res, 0);
        chk("div0_rem", last_rem, 9);
        chk("div0_flags", last_fl, 4'b0101);
        chk("div0_lat", last_lat, 1);

        run1(3'd6, 32'd3, 32'd5);
        chk("pow_res", last_res, 243);
        chk("pow_flags", last_fl, 4'b0000);
        chk("pow_lat", last_lat, 5);
        run1(3'd6, 32'h1_0000, 32'd3);
        chk("pow_ovf_res", last_res, 0);
        chk("pow_ovf_flags", last_fl, 4'b0101);
        run1(3'd6, 32'd7, 32'd0);
        chk("pow0_res", last_res, 1);
        chk("pow0_lat", last_lat, 1);

        run1(3'd4, 32'h1_0000, 32'h1_0000);
        chk("mul_res", last_res, 0);
        chk("mul_flags", last_fl, 4'b0101);
        run1(3'd7, 32'd123, 32'd456);
        chk("rsvd_res", last_res, 0);
        chk("rsvd_flags", last_fl, 4'b0100);

        // Back-to-back single-cycle ops with a never-stalling consumer.
        tgt = n_done + 3;
        send(3'd0, 32'd10, 32'd20, w0);
        send(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, w1);
        send(3'd3, 32'h0000_00F0, 32'h0000_000F, w2);
        idle();
        wait_done(tgt);
        chk("b2b_accept1", w1, 1);
        chk("b2b_accept2", w2, 1);
        chk("b2b_last", last_res, 32'h0000_00FF);

        // Backpressure: result held 4 cycles while a second op waits.
        out_ready = 1'b0;
        tgt = n_done + 2;
        send(3'd0, 32'd1, 32'd2, w0);
        fork
            send(3'd1, 32'd3, 32'd5, w1);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        wait_done(tgt);
        chk("bp_accept_wait", w1, 5);
        chk("bp_sub_res", last_res, 32'hFFFF_FFFE);
        chk("bp_sub_flags", last_fl, 4'b1000);

        // Reset in the middle of a divide.
        done0 = n_done;
        send(3'd5, 32'd100, 32'd7, w0);
        idle();
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", Result, 0);
        chk("midrst_flags", ALUFlags, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_output", n_done, done0);
        run1(3'd5, 32'd1000, 32'd33);
        chk("post_rst_res", last_res, 30);
        chk("post_rst_rem", last_rem, 10);

        // Randomised traffic with random gaps and random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (op == 3'd5 && $urandom_range(0, 1) == 1) b = W'($urandom_range(1, 300));
            if (op == 3'd6) b = W'($urandom);
            send(op, a, b, w0);
            idle();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
